sd_lun_arbiter: RTL and testbench

- Downstream of the cartridge floppy controllers. Merges the sector-request ports (lba, rd, wr, buffer) of up to CLIENTS disk devices onto the single MiSTer SD block interface.
- Grants one request at a time and rotates priority round-robin.
- Steers the host ack and the buffer write strobe to the granted client only, and muxes that client's outgoing buffer data back to the host.

---
 rtl/sd_lun_arbiter_pkg.sv | 21 ++
 rtl/sd_lun_arbiter_if.sv | 39 +++
 rtl/sd_lun_arbiter_rr_pick.sv | 37 +++
 rtl/sd_lun_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sd_lun_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sd_lun_arbiter_pkg.sv
// Shared types and constants for the SD LUN arbiter slice.
package sd_arb_pkg;

  localparam int MAX_CLIENTS = 8;
  localparam int LBA_W       = 32;
  localparam int GID_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  // Round-robin successor of a client index, wrapping at the client count.
  function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] id, input int clients);
    if (int'(id) + 1 >= clients) return '0;
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/sd_lun_arbiter_if.sv
// Client-side sector ports plus the host SD block interface, bundled.
// master = arbiter view, slave = clients/host view.
interface sd_lun_arbiter_if
  import sd_arb_pkg::*;
#(
  parameter int CLIENTS = 2
);

  logic [LBA_W*CLIENTS-1:0] c_lba;
  logic [CLIENTS-1:0]       c_rd;
  logic [CLIENTS-1:0]       c_wr;
  logic [CLIENTS-1:0]       c_ack;
  logic [CLIENTS-1:0]       c_buff_wr;
  logic [8*CLIENTS-1:0]     c_buff_din;

  logic [LBA_W-1:0]         sd_lba;
  logic                     sd_rd;
  logic                     sd_wr;
  logic                     sd_ack;
  logic                     sd_buff_wr;
  logic [7:0]               sd_buff_din;

  logic                     busy;
  logic [GID_W-1:0]         grant_id;
  logic                     timeout_err;

  modport master (
    input  c_lba, c_rd, c_wr, c_buff_din, sd_ack, sd_buff_wr,
    output c_ack, c_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din,
           busy, grant_id, timeout_err
  );

  modport slave (
    output c_lba, c_rd, c_wr, c_buff_din, sd_ack, sd_buff_wr,
    input  c_ack, c_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din,
           busy, grant_id, timeout_err
  );

endinterface

// File: rtl/sd_lun_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after
// the pointer, scanning circularly upward.
module rr_pick
  import sd_arb_pkg::*;
#(
  parameter int CLIENTS = 2
) (
  input  logic [CLIENTS-1:0] i_req,
  input  logic [GID_W-1:0]   i_ptr,
  output logic [GID_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [MAX_CLIENTS-1:0] w_req_pad;
  int                     w_pos;
  logic [GID_W-1:0]       w_cand;

  assign w_req_pad = MAX_CLIENTS'(i_req);

  // Circular scan from the pointer; the first hit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= CLIENTS) w_pos = w_pos - CLIENTS;
      w_cand = GID_W'(w_pos);
      if (!o_valid && w_req_pad[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_lun_arbiter.sv
// Merges per-client sector requests onto the single SD block interface,
// one grant at a time with round-robin priority.
//
// state | meaning
// IDLE  | no grant; pick next requester from the pointer
// REQ   | host request raised, waiting for sd_ack (watchdog counting)
// XFER  | host transfer in progress, routed to grant_id
// GAP   | one dead cycle so the served client can drop its request
module sd_lun_arbiter
  import sd_arb_pkg::*;
#(
  parameter int CLIENTS = 2,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  sd_lun_arbiter_if.master bus
);

  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t       r_state, w_state_nxt;
  logic [GID_W-1:0] r_ptr, w_ptr_nxt;
  logic [GID_W-1:0] r_grant_id, w_grant_nxt;
  logic [LBA_W-1:0] r_lba, w_lba_nxt;
  logic             r_sd_rd, w_sd_rd_nxt;
  logic             r_sd_wr, w_sd_wr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;
  logic [WD_W-1:0]  r_wd_cnt, w_wd_cnt_nxt;

  logic [MAX_CLIENTS-1:0] w_rd_pad;
  logic [MAX_CLIENTS-1:0] w_wr_pad;
  logic [LBA_W-1:0]       w_lba_arr [MAX_CLIENTS];
  logic [7:0]             w_din_arr [MAX_CLIENTS];
  logic [GID_W-1:0]       w_win_id;
  logic                   w_win_vld;
  logic                   w_granted;
  logic                   w_wd_fire;

  // Pad client vectors to MAX_CLIENTS so a 3-bit grant index is always in range.
  for (genvar gi = 0; gi < MAX_CLIENTS; gi++) begin : g_pad
    if (gi < CLIENTS) begin : g_used
      assign w_rd_pad[gi]  = bus.c_rd[gi];
      assign w_wr_pad[gi]  = bus.c_wr[gi];
      assign w_lba_arr[gi] = bus.c_lba[LBA_W*gi +: LBA_W];
      assign w_din_arr[gi] = bus.c_buff_din[8*gi +: 8];
    end else begin : g_unused
      assign w_rd_pad[gi]  = 1'b0;
      assign w_wr_pad[gi]  = 1'b0;
      assign w_lba_arr[gi] = '0;
      assign w_din_arr[gi] = 8'hFF;
    end
  end

  rr_pick #(.CLIENTS(CLIENTS)) u_pick (
    .i_req   (bus.c_rd | bus.c_wr),
    .i_ptr   (r_ptr),
    .o_idx   (w_win_id),
    .o_valid (w_win_vld)
  );

  assign w_wd_fire = (TIMEOUT > 0) && (r_wd_cnt == '0);

  // State and registered-output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_lba         <= '0;
      r_sd_rd       <= 1'b0;
      r_sd_wr       <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant_id    <= w_grant_nxt;
      r_lba         <= w_lba_nxt;
      r_sd_rd       <= w_sd_rd_nxt;
      r_sd_wr       <= w_sd_wr_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_wd_cnt      <= w_wd_cnt_nxt;
    end
  end

  // Next-state decode; an ack coinciding with the watchdog firing wins.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_win_vld) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.sd_ack)     w_state_nxt = ST_XFER;
        else if (w_wd_fire) w_state_nxt = ST_GAP;
      end
      ST_XFER: if (!bus.sd_ack) w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, latches and watchdog down-counter.
  always_comb begin
    w_grant_nxt       = r_grant_id;
    w_lba_nxt         = r_lba;
    w_sd_rd_nxt       = r_sd_rd;
    w_sd_wr_nxt       = r_sd_wr;
    w_ptr_nxt         = r_ptr;
    w_wd_cnt_nxt      = r_wd_cnt;
    w_timeout_err_nxt = 1'b0;
    w_busy_nxt        = (w_state_nxt != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_grant_nxt  = w_win_id;
          w_lba_nxt    = w_lba_arr[w_win_id];
          // Read wins when both are set; the write is served on a later grant.
          w_sd_rd_nxt  = w_rd_pad[w_win_id];
          w_sd_wr_nxt  = w_wr_pad[w_win_id] & ~w_rd_pad[w_win_id];
          w_wd_cnt_nxt = WD_LOAD;
        end
      end
      ST_REQ: begin
        if (bus.sd_ack) begin
          w_sd_rd_nxt = 1'b0;
          w_sd_wr_nxt = 1'b0;
        end else if (w_wd_fire) begin
          w_sd_rd_nxt       = 1'b0;
          w_sd_wr_nxt       = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_ptr_nxt         = next_ptr(r_grant_id, CLIENTS);
        end else begin
          w_wd_cnt_nxt = r_wd_cnt - 1'b1;
        end
      end
      ST_XFER: begin
        if (!bus.sd_ack) w_ptr_nxt = next_ptr(r_grant_id, CLIENTS);
      end
      default: ;
    endcase
  end

  // Ack and strobe reach only the granted client, and only while REQ/XFER.
  assign w_granted = (r_state == ST_REQ) || (r_state == ST_XFER);

  for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_route
    assign bus.c_ack[gi]     = w_granted && (r_grant_id == GID_W'(gi)) && bus.sd_ack;
    assign bus.c_buff_wr[gi] = w_granted && (r_grant_id == GID_W'(gi)) && bus.sd_ack
                               && bus.sd_buff_wr;
  end

  assign bus.sd_buff_din = w_granted ? w_din_arr[r_grant_id] : 8'hFF;
  assign bus.sd_lba      = r_lba;
  assign bus.sd_rd       = r_sd_rd;
  assign bus.sd_wr       = r_sd_wr;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sd_lun_arbiter.sv
// Directed bench for sd_lun_arbiter with two clients and a 16-cycle watchdog.
module tb_sd_lun_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sd_lun_arbiter_if #(.CLIENTS(2)) bus ();

  sd_lun_arbiter #(.CLIENTS(2), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_host_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.sd_rd || bus.sd_wr) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Host side of one transfer, starting in REQ: ack after lat cycles, hold
  // for len cycles, then walk through GAP into IDLE.
  task automatic run_xfer(input int gid, input int lat, input int len, input logic [7:0] exp_din);
    logic [1:0] own;
    bit         leak, din_bad, strobe_bad;
    own = 2'(1 << gid);
    repeat (lat) step();
    chk_val("req_held", 32'(bus.sd_rd | bus.sd_wr), 32'd1);
    chk_val("no_ack_before_host", 32'(bus.c_ack), 32'd0);
    bus.sd_ack = 1'b1;
    #1;
    chk_val("ack_same_cycle", 32'(bus.c_ack), 32'(own));
    step();
    chk_val("req_drop_after_ack", 32'({bus.sd_rd, bus.sd_wr}), 32'd0);
    bus.c_rd = bus.c_rd & ~own;
    bus.c_wr = bus.c_wr & ~own;
    leak = 1'b0; din_bad = 1'b0; strobe_bad = 1'b0;
    for (int i = 0; i < len - 1; i++) begin
      bus.sd_buff_wr = (i % 3 != 0);
      #1;
      if (bus.c_buff_wr !== (bus.sd_buff_wr ? own : 2'b00)) strobe_bad = 1'b1;
      if (bus.c_ack !== own) leak = 1'b1;
      if (bus.sd_buff_din !== exp_din) din_bad = 1'b1;
      step();
    end
    chk_val("strobe_routing", 32'(strobe_bad), 32'd0);
    chk_val("ack_routing", 32'(leak), 32'd0);
    chk_val("buff_din_mux", 32'(din_bad), 32'd0);
    bus.sd_ack = 1'b0;
    bus.sd_buff_wr = 1'b0;
    #1;
    chk_val("ack_follows_fall", 32'(bus.c_ack), 32'd0);
    chk_val("busy_in_xfer", 32'(bus.busy), 32'd1);
    step();
    bus.sd_ack = 1'b1;
    #1;
    chk_val("gap_ack_ignored", 32'(bus.c_ack), 32'd0);
    chk_val("gap_busy", 32'(bus.busy), 32'd1);
    chk_val("gap_din_ff", 32'(bus.sd_buff_din), 32'hFF);
    chk_val("gap_grant_id", 32'(bus.grant_id), 32'(gid));
    bus.sd_ack = 1'b0;
    step();
    chk_val("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    bit ok;
    int n_rd, n_terr;
    bit got1;

    bus.c_lba      = '0;
    bus.c_rd       = '0;
    bus.c_wr       = '0;
    bus.c_buff_din = 16'hA53C;
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;

    // Reset values
    step(); step();
    chk_val("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
    chk_val("rst_sd_wr", 32'(bus.sd_wr), 32'd0);
    chk_val("rst_busy", 32'(bus.busy), 32'd0);
    chk_val("rst_terr", 32'(bus.timeout_err), 32'd0);
    chk_val("rst_lba", bus.sd_lba, 32'd0);
    chk_val("rst_grant", 32'(bus.grant_id), 32'd0);
    chk_val("rst_c_ack", 32'(bus.c_ack), 32'd0);
    chk_val("rst_c_buff_wr", 32'(bus.c_buff_wr), 32'd0);
    chk_val("rst_din", 32'(bus.sd_buff_din), 32'hFF);
    reset = 1'b0;
    step();

    // Single read from client 0
    bus.c_lba = {32'h0, 32'h0000_0123};
    bus.c_rd  = 2'b01;
    step();
    chk_val("t1_lba", bus.sd_lba, 32'h123);
    chk_val("t1_rd", 32'(bus.sd_rd), 32'd1);
    chk_val("t1_wr", 32'(bus.sd_wr), 32'd0);
    chk_val("t1_grant", 32'(bus.grant_id), 32'd0);
    chk_val("t1_busy", 32'(bus.busy), 32'd1);
    run_xfer(0, 3, 512, 8'h3C);

    // Contention after reset: 0 then 1
    reset = 1'b1; step(); reset = 1'b0; step();
    bus.c_lba = {32'h0000_2000, 32'h0000_1000};
    bus.c_rd  = 2'b11;
    step();
    chk_val("t2_grant_a", 32'(bus.grant_id), 32'd0);
    chk_val("t2_lba_a", bus.sd_lba, 32'h1000);
    run_xfer(0, 2, 16, 8'h3C);
    wait_host_req(ok);
    chk_val("t2_wait_b", 32'(ok), 32'd1);
    chk_val("t2_grant_b", 32'(bus.grant_id), 32'd1);
    chk_val("t2_lba_b", bus.sd_lba, 32'h2000);
    chk_val("t2_rd_b", 32'(bus.sd_rd), 32'd1);
    run_xfer(1, 1, 16, 8'hA5);

    // Fairness: both keep requesting, grants alternate 0,1,0,1
    bus.c_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_host_req(ok);
      chk_val("t3_wait", 32'(ok), 32'd1);
      chk_val("t3_grant_seq", 32'(bus.grant_id), 32'(k % 2));
      run_xfer(k % 2, 1, 8, (k % 2 == 1) ? 8'hA5 : 8'h3C);
      if (k < 3) bus.c_rd = 2'b11;
    end
    bus.c_rd = 2'b00;

    // Write path from client 1
    bus.c_wr = 2'b10;
    #1;
    chk_val("t4_idle_din", 32'(bus.sd_buff_din), 32'hFF);
    step();
    chk_val("t4_wr", 32'(bus.sd_wr), 32'd1);
    chk_val("t4_rd", 32'(bus.sd_rd), 32'd0);
    chk_val("t4_grant", 32'(bus.grant_id), 32'd1);
    run_xfer(1, 2, 32, 8'hA5);
    chk_val("t4_after_din", 32'(bus.sd_buff_din), 32'hFF);

    // Read wins over write on the same client
    bus.c_rd = 2'b01;
    bus.c_wr = 2'b01;
    step();
    chk_val("t4b_rd", 32'(bus.sd_rd), 32'd1);
    chk_val("t4b_wr", 32'(bus.sd_wr), 32'd0);
    chk_val("t4b_grant", 32'(bus.grant_id), 32'd0);
    run_xfer(0, 1, 8, 8'h3C);

    // Reset in the middle of a transfer
    bus.c_rd = 2'b10;
    step();
    chk_val("t5_grant", 32'(bus.grant_id), 32'd1);
    step(); step();
    bus.sd_ack = 1'b1;
    step();
    for (int a = 0; a < 100; a++) begin
      bus.sd_buff_wr = 1'b1;
      step();
    end
    reset = 1'b1;
    #1;
    chk_val("t5_rst_rd", 32'(bus.sd_rd), 32'd0);
    chk_val("t5_rst_wr", 32'(bus.sd_wr), 32'd0);
    chk_val("t5_rst_ack", 32'(bus.c_ack), 32'd0);
    chk_val("t5_rst_strobe", 32'(bus.c_buff_wr), 32'd0);
    chk_val("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk_val("t5_rst_grant", 32'(bus.grant_id), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk_val("t5_idle_ack_ignored", 32'(bus.c_ack), 32'd0);
    bus.sd_ack = 1'b0;
    bus.sd_buff_wr = 1'b0;
    step();
    chk_val("t5_regrant", 32'(bus.grant_id), 32'd1);
    chk_val("t5_regrant_rd", 32'(bus.sd_rd), 32'd1);
    run_xfer(1, 2, 16, 8'hA5);

    // Watchdog: no host ack for client 0, client 1 waiting
    bus.c_rd = 2'b11;
    step();
    chk_val("t6_grant0", 32'(bus.grant_id), 32'd0);
    n_rd = 0; n_terr = 0; got1 = 1'b0;
    for (int i = 0; i < 40 && !got1; i++) begin
      if (bus.sd_rd && bus.grant_id == 3'd0) n_rd++;
      if (bus.timeout_err) n_terr++;
      if (bus.sd_rd && bus.grant_id == 3'd1) got1 = 1'b1;
      else step();
    end
    chk_val("t6_req_cycles", 32'(n_rd), 32'd16);
    chk_val("t6_terr_pulses", 32'(n_terr), 32'd1);
    chk_val("t6_next_grant", 32'(got1), 32'd1);
    run_xfer(1, 1, 8, 8'hA5);
    bus.c_rd = 2'b00;
    step(); step();
    chk_val("t6_end_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
